board_drawer: RTL and testbench
===============================

Name: board_drawer

Overview:
Reader side of the game core's board[199:0] output. On each redraw request it snapshots the 10x20 board and walks it cell by cell. It emits one pixel-write transaction per pixel to the VGA framebuffer adapter (160x120, 3-bit colour), with a valid/ready handshake. After the first frame it redraws only cells whose occupancy changed since the last completed frame, which keeps per-tick framebuffer traffic small.

Parameters:
CELL_PX, 5, cell edge length in pixels
ORIGIN_X, 55, framebuffer x of the top-left pixel of cell (row 0, col 0)
ORIGIN_Y, 10, framebuffer y of the top-left pixel of cell (row 0, col 0)
X_W, 8, width of x output
Y_W, 7, width of y output
FG_COLOUR, 3'b111, colour for an occupied cell
BG_COLOUR, 3'b000, colour for an empty cell

Ports:
clk  in  1  system clock (50 MHz)
resetn  in  1  synchronous, active-low reset
board  in  200  board state; bit index = row*10 + col, row 0 = top, col 0 = left, 1 = occupied
start  in  1  redraw request; sampled only in IDLE
plot_ready  in  1  framebuffer accepts the current pixel
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when a redraw completes
x  out  X_W  pixel x coordinate
y  out  Y_W  pixel y coordinate
colour  out  3  pixel colour
plot  out  1  pixel valid; a transfer occurs on a cycle with plot && plot_ready

Behaviour:
- Reset: synchronous, active-low, takes priority in any state.
  - Outputs after reset: plot=0, busy=0, done=0, x=0, y=0, colour=0.
  - Internal state after reset: state=IDLE, snap=0, prev=0, prev_valid=0.
- States: IDLE, SCAN, PIXEL, FINISH.
- IDLE:
  - On start=1 at edge k: snap<=board, row=col=0, go to SCAN; busy=1 from cycle k+1.
  - Changes on board at other times are ignored.
- SCAN: evaluates cell (row,col), one cycle per cell.
  - The cell must be drawn if prev_valid=0 or snap[idx]!=prev[idx].
    - If drawn: px=py=0, go to PIXEL; plot asserts on the next cycle.
    - Otherwise: advance the cell with plot=0.
  - Cell order is row-major: col 0..9, then the next row.
  - After cell (19,9) is handled, go to FINISH.
- PIXEL:
  - plot=1, x=ORIGIN_X+col*CELL_PX+px, y=ORIGIN_Y+row*CELL_PX+py.
  - colour=FG_COLOUR if snap[idx], else BG_COLOUR.
  - Pixel order is row-major inside the cell: px 0..CELL_PX-1, then py.
  - On a transfer:
    - Not the last pixel of the cell: advance to the next pixel.
    - Last pixel: advance the cell and return to SCAN.
    - Last pixel of cell (19,9): go to FINISH.
  - Backpressure: while plot=1 and plot_ready=0, x, y, colour and plot stay stable and counters do not advance.
- FINISH: one cycle.
  - prev<=snap, prev_valid<=1, done=1, busy=0, return to IDLE.
  - The next start is accepted in the cycle after done.
- start while busy is ignored and is not queued.
- start held high: one redraw per pass through IDLE.
- Arithmetic: coordinates are computed at full internal width and truncated to X_W/Y_W. Parameters must keep the grid inside the frame (checked by an elaboration-time assertion).
- Reset mid-frame: plot drops the cycle after the reset edge, and prev_valid=0, so the next redraw is a full redraw.
- Minimum frame time (no changes): 1 + 200 + 1 cycles.
- Full frame with plot_ready held high: 200*CELL_PX*CELL_PX = 5000 transfers.

Decomposition:
- Shared package tetris_pkg holds:
  - BOARD_COLS=10, BOARD_ROWS=20, BOARD_BITS=200
  - typedef colour_t (logic [2:0])
  - function cell_idx(row,col) returning row*10+col; the game core uses the same function.
- Sub-module cell_pixel_counter: nested px/py/col/row counters.
  - Inputs: step_pixel, step_cell.
  - Outputs: last_pixel_of_cell, last_cell.
- board_drawer keeps the FSM, the snapshot/prev registers and the coordinate datapath.

Test Plan:
1. Reset, board=0, start pulse with plot_ready=1 -> exactly 5000 transfers, all colour 000. First transfer is x=55,y=10; last is x=104,y=109. done pulses once; busy is low afterwards.
2. After test 1, set board bit 0 and pulse start -> exactly 25 transfers, colour 111, x 55..59, y 10..14. Then set bit 199, clear bit 0 and pulse start -> 25 transfers at x 100..104, y 105..109 with colour 111, plus 25 transfers at x 55..59, y 10..14 with colour 000; 50 transfers in total.
3. Pulse start with an unchanged board -> zero transfers; done arrives 202 cycles after start.
4. Backpressure: drive plot_ready low for 3 cycles at the 7th pixel of a cell -> x/y/colour/plot stay stable for those cycles. Total transfers are unchanged and no pixel is duplicated or skipped.
5. Pulse start at cycle 50 of a busy frame and change board mid-frame -> no extra frame runs, and the drawn pixels reflect the snapshot taken at accept.
6. Assert resetn=0 during PIXEL -> plot=0 and busy=0 the cycle after the edge. The next start yields a full 5000-transfer redraw.

Source files
------------

// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Board geometry, colour type, drawer states and the cell-index
//               helper shared by the game core and the board drawer.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 20;
    localparam int BOARD_BITS = BOARD_COLS * BOARD_ROWS;

    localparam int COL_W = $clog2(BOARD_COLS);
    localparam int ROW_W = $clog2(BOARD_ROWS);
    localparam int IDX_W = $clog2(BOARD_BITS);

    // Framebuffer geometry of the VGA adapter
    localparam int FB_W = 160;
    localparam int FB_H = 120;

    typedef logic [2:0] colour_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_PIXEL  = 2'd2,
        S_FINISH = 2'd3
    } draw_state_t;

    // Flat board bit for (row, col); row 0 is the top row
    function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
        return IDX_W'(int'(row) * BOARD_COLS + int'(col));
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_drawer_if.sv
`default_nettype none
// ============================================================================
// Module      : board_drawer_if
// Description : Pixel-write channel from the board drawer to the framebuffer
//               adapter; a pixel moves on a cycle with plot && plot_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface board_drawer_if
    import tetris_pkg::*;
#(
    parameter int X_W = 8,
    parameter int Y_W = 7
) ();

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    colour_t        colour;
    logic           plot;
    logic           plot_ready;

    modport master (output x, output y, output colour, output plot, input plot_ready);
    modport slave  (input x, input y, input colour, input plot, output plot_ready);

endinterface
`default_nettype wire

// File: rtl/cell_pixel_counter.sv
`default_nettype none
// ============================================================================
// Module      : cell_pixel_counter
// Description : Nested pixel (px, py) and cell (col, row) counters used to
//               walk the board row-major and each cell row-major.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_pixel_counter
    import tetris_pkg::*;
#(
    parameter int CELL_PX = 5,
    parameter int PX_W    = $clog2(CELL_PX + 1)
)(
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             step_pixel,
    input  logic             step_cell,
    output logic [PX_W-1:0]  px,
    output logic [PX_W-1:0]  py,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last_pixel_of_cell,
    output logic             last_cell
);

    logic [PX_W-1:0]  r_px;
    logic [PX_W-1:0]  r_py;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             w_last_px;
    logic             w_last_col;

    assign w_last_px          = (r_px == PX_W'(CELL_PX - 1));
    assign w_last_col         = (r_col == COL_W'(BOARD_COLS - 1));
    assign last_pixel_of_cell = w_last_px && (r_py == PX_W'(CELL_PX - 1));
    assign last_cell          = w_last_col && (r_row == ROW_W'(BOARD_ROWS - 1));

    assign px  = r_px;
    assign py  = r_py;
    assign col = r_col;
    assign row = r_row;

    // Advance to the next cell (restarting its pixel walk) or to the next pixel
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            r_px  <= '0;
            r_py  <= '0;
            r_col <= '0;
            r_row <= '0;
        end else if (step_cell) begin
            r_px <= '0;
            r_py <= '0;
            if (w_last_col) begin
                r_col <= '0;
                r_row <= last_cell ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end else if (step_pixel) begin
            if (w_last_px) begin
                r_px <= '0;
                r_py <= r_py + 1'b1;
            end else begin
                r_px <= r_px + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/board_drawer.sv
`default_nettype none
// ============================================================================
// Module      : board_drawer
// Description : Snapshots the 10x20 board on a redraw request and streams
//               pixel writes for every cell that changed since the last
//               completed frame (all cells on the first frame).
// Revision    : 1.0 - initial release
// ============================================================================
module board_drawer
    import tetris_pkg::*;
#(
    parameter int      CELL_PX   = 5,
    parameter int      ORIGIN_X  = 55,
    parameter int      ORIGIN_Y  = 10,
    parameter int      X_W       = 8,
    parameter int      Y_W       = 7,
    parameter colour_t FG_COLOUR = 3'b111,
    parameter colour_t BG_COLOUR = 3'b000
)(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [BOARD_BITS-1:0] board,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    board_drawer_if.master        pix
);

    localparam int PX_W = $clog2(CELL_PX + 1);

    // The grid must lie inside the framebuffer and be addressable by x/y
    if ((ORIGIN_X + BOARD_COLS * CELL_PX > FB_W) ||
        (ORIGIN_Y + BOARD_ROWS * CELL_PX > FB_H) ||
        (ORIGIN_X + BOARD_COLS * CELL_PX - 1 >= (1 << X_W)) ||
        (ORIGIN_Y + BOARD_ROWS * CELL_PX - 1 >= (1 << Y_W))) begin : g_grid_check
        $error("board_drawer: board grid does not fit the framebuffer");
    end

    draw_state_t           r_state;
    logic [BOARD_BITS-1:0] r_snap;
    logic [BOARD_BITS-1:0] r_prev;
    logic                  r_prev_valid;
    logic                  r_plot;
    logic                  r_busy;
    logic                  r_done;
    logic [X_W-1:0]        r_x;
    logic [Y_W-1:0]        r_y;
    colour_t               r_colour;

    logic [PX_W-1:0]  w_px;
    logic [PX_W-1:0]  w_py;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_last_pix;
    logic             w_last_cell;
    logic [IDX_W-1:0] w_idx;
    logic             w_draw;
    logic             w_xfer;
    logic             w_px_wrap;
    logic [PX_W-1:0]  w_px_nxt;
    logic [PX_W-1:0]  w_py_nxt;
    logic [31:0]      w_base_x;
    logic [31:0]      w_base_y;
    logic [31:0]      w_nx;
    logic [31:0]      w_ny;

    assign w_idx  = cell_idx(w_row, w_col);
    assign w_draw = !r_prev_valid || (r_snap[w_idx] != r_prev[w_idx]);
    assign w_xfer = r_plot && pix.plot_ready;

    // Coordinates at full width; x/y registers keep only the low bits
    assign w_base_x  = 32'(ORIGIN_X) + 32'(w_col) * 32'(CELL_PX);
    assign w_base_y  = 32'(ORIGIN_Y) + 32'(w_row) * 32'(CELL_PX);
    assign w_px_wrap = (w_px == PX_W'(CELL_PX - 1));
    assign w_px_nxt  = w_px_wrap ? '0 : w_px + 1'b1;
    assign w_py_nxt  = w_px_wrap ? w_py + 1'b1 : w_py;
    assign w_nx      = w_base_x + 32'(w_px_nxt);
    assign w_ny      = w_base_y + 32'(w_py_nxt);

    cell_pixel_counter #(
        .CELL_PX (CELL_PX),
        .PX_W    (PX_W)
    ) u_counter (
        .clk                (clk),
        .resetn             (resetn),
        .clear              (r_state == S_IDLE),
        .step_pixel         ((r_state == S_PIXEL) && w_xfer && !w_last_pix),
        .step_cell          (((r_state == S_SCAN) && !w_draw) ||
                             ((r_state == S_PIXEL) && w_xfer && w_last_pix)),
        .px                 (w_px),
        .py                 (w_py),
        .col                (w_col),
        .row                (w_row),
        .last_pixel_of_cell (w_last_pix),
        .last_cell          (w_last_cell)
    );

    // Redraw sequencer: snapshot, scan cells, stream pixels, commit the frame
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_snap       <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_plot       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_colour     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_snap  <= board;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_draw) begin
                        r_plot   <= 1'b1;
                        r_x      <= w_base_x[X_W-1:0];
                        r_y      <= w_base_y[Y_W-1:0];
                        r_colour <= r_snap[w_idx] ? FG_COLOUR : BG_COLOUR;
                        r_state  <= S_PIXEL;
                    end else if (w_last_cell) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_FINISH;
                    end
                end
                S_PIXEL: begin
                    if (w_xfer) begin
                        if (!w_last_pix) begin
                            r_x <= w_nx[X_W-1:0];
                            r_y <= w_ny[Y_W-1:0];
                        end else begin
                            r_plot <= 1'b0;
                            if (w_last_cell) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_FINISH;
                            end else begin
                                r_state <= S_SCAN;
                            end
                        end
                    end
                end
                S_FINISH: begin
                    r_prev       <= r_snap;
                    r_prev_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign pix.plot   = r_plot;
    assign pix.x      = r_x;
    assign pix.y      = r_y;
    assign pix.colour = r_colour;

endmodule
`default_nettype wire

// File: tb/tb_board_drawer.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_drawer
// Description : Self-checking bench for board_drawer. A reference model
//               pushes the expected pixel stream when a redraw is requested;
//               a monitor pops and compares on every transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_drawer;

    localparam int C_CELL = 5;
    localparam int C_OX   = 55;
    localparam int C_OY   = 10;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic         start  = 1'b0;
    logic [199:0] board  = '0;
    logic         busy;
    logic         done;

    int   n_vec       = 0;
    int   n_err       = 0;
    int   frame_xfers = 0;
    int   done_count  = 0;
    int   first_x, first_y, last_x, last_y;
    pix_t sb_q[$];

    logic [199:0] m_prev       = '0;
    bit           m_prev_valid = 1'b0;

    board_drawer_if #(.X_W(8), .Y_W(7)) bif ();

    board_drawer #(
        .CELL_PX   (5),
        .ORIGIN_X  (55),
        .ORIGIN_Y  (10),
        .X_W       (8),
        .Y_W       (7),
        .FG_COLOUR (3'b111),
        .BG_COLOUR (3'b000)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .board  (board),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .pix    (bif.master)
    );

    always #10 clk = ~clk;

    // Reference model: expected pixels of one redraw of board b
    function automatic int push_frame(input logic [199:0] b);
        int   cnt;
        pix_t p;
        cnt = 0;
        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < 10; c++) begin
                if (!m_prev_valid || (b[r*10+c] != m_prev[r*10+c])) begin
                    for (int py = 0; py < C_CELL; py++) begin
                        for (int px = 0; px < C_CELL; px++) begin
                            p.x = 8'(C_OX + c*C_CELL + px);
                            p.y = 7'(C_OY + r*C_CELL + py);
                            p.c = b[r*10+c] ? 3'b111 : 3'b000;
                            sb_q.push_back(p);
                            cnt++;
                        end
                    end
                end
            end
        end
        m_prev       = b;
        m_prev_valid = 1'b1;
        return cnt;
    endfunction

    // Transfer monitor and scoreboard
    always @(negedge clk) begin
        pix_t e;
        #1;
        if (done === 1'b1) done_count++;
        if (bif.plot === 1'b1 && bif.plot_ready === 1'b1) begin
            frame_xfers++;
            if (frame_xfers == 1) begin
                first_x = int'(bif.x);
                first_y = int'(bif.y);
            end
            last_x = int'(bif.x);
            last_y = int'(bif.y);
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got x=%0d y=%0d colour=%0d, required no transfer",
                         bif.x, bif.y, bif.colour);
            end else begin
                e = sb_q.pop_front();
                if (bif.x !== e.x || bif.y !== e.y || bif.colour !== e.c) begin
                    n_err++;
                    $display("FAIL sb_pixel: got x=%0d y=%0d colour=%0d, required x=%0d y=%0d colour=%0d",
                             bif.x, bif.y, bif.colour, e.x, e.y, e.c);
                end
            end
        end
    end

    // One redraw: push expectations, pulse start, wait for done, check totals
    task automatic do_redraw(input string name, input int exp_xfers,
                             input int max_cycles, output int cycles);
        int n, d0, pushed;
        frame_xfers = 0;
        d0          = done_count;
        pushed      = push_frame(board);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 2;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s_busy_rise: got busy=%b, required 1", name, busy);
        end
        while (done !== 1'b1 && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_done_timeout: got no done in %0d cycles, required done", name, n);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_busy_at_done: got busy=%b, required 0", name, busy);
        end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_after_done: got done=%b busy=%b, required 0 0", name, done, busy);
        end
        n_vec++;
        if (frame_xfers != exp_xfers || pushed != exp_xfers) begin
            n_err++;
            $display("FAIL %s_xfer_count: got %0d (model %0d), required %0d",
                     name, frame_xfers, pushed, exp_xfers);
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing_pixels: got %0d left, required 0", name, sb_q.size());
        end
        n_vec++;
        if (done_count - d0 != 1) begin
            n_err++;
            $display("FAIL %s_done_pulses: got %0d, required 1", name, done_count - d0);
        end
        cycles = n;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bif.plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got plot=%b busy=%b done=%b, required 0 0 0",
                     bif.plot, busy, done);
        end
        n_vec++;
        if (bif.x !== 8'd0 || bif.y !== 7'd0 || bif.colour !== 3'd0) begin
            n_err++;
            $display("FAIL reset_data: got x=%0d y=%0d colour=%0d, required 0 0 0",
                     bif.x, bif.y, bif.colour);
        end
        @(negedge clk);
        resetn       = 1'b1;
        m_prev       = '0;
        m_prev_valid = 1'b0;
    endtask

    task automatic test_full_frame();
        int cyc;
        board = '0;
        do_redraw("full", 5000, 6000, cyc);
        n_vec++;
        if (first_x != 55 || first_y != 10) begin
            n_err++;
            $display("FAIL full_first: got x=%0d y=%0d, required x=55 y=10", first_x, first_y);
        end
        n_vec++;
        if (last_x != 104 || last_y != 109) begin
            n_err++;
            $display("FAIL full_last: got x=%0d y=%0d, required x=104 y=109", last_x, last_y);
        end
    endtask

    task automatic test_incremental();
        int cyc;
        board[0] = 1'b1;
        do_redraw("inc_one", 25, 500, cyc);
        board[199] = 1'b1;
        board[0]   = 1'b0;
        do_redraw("inc_two", 50, 600, cyc);
    endtask

    task automatic test_no_change();
        int cyc;
        do_redraw("nochange", 0, 400, cyc);
        n_vec++;
        if (cyc != 202) begin
            n_err++;
            $display("FAIL nochange_latency: got %0d cycles, required 202", cyc);
        end
    endtask

    task automatic test_backpressure();
        int         cyc, g;
        logic [7:0] hx;
        logic [6:0] hy;
        logic [2:0] hc;
        board[5]    = 1'b1;
        frame_xfers = 0;
        fork
            do_redraw("bp", 25, 1000, cyc);
            begin
                g = 0;
                while (frame_xfers != 6 && g < 1000) begin
                    @(negedge clk);
                    g++;
                end
                bif.plot_ready = 1'b0;
                hx = bif.x;
                hy = bif.y;
                hc = bif.colour;
                n_vec++;
                if (bif.plot !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_plot_at_stall: got plot=%b, required 1", bif.plot);
                end
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    n_vec++;
                    if (bif.plot !== 1'b1 || bif.x !== hx || bif.y !== hy || bif.colour !== hc) begin
                        n_err++;
                        $display("FAIL bp_hold: got plot=%b x=%0d y=%0d colour=%0d, required 1 %0d %0d %0d",
                                 bif.plot, bif.x, bif.y, bif.colour, hx, hy, hc);
                    end
                end
                bif.plot_ready = 1'b1;
            end
        join
        n_vec++;
        if (hx !== 8'd81 || hy !== 7'd11 || hc !== 3'b111) begin
            n_err++;
            $display("FAIL bp_stalled_pixel: got x=%0d y=%0d colour=%0d, required 81 11 7", hx, hy, hc);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc, d0, x0;
        board[30]  = 1'b1;
        board[120] = 1'b1;
        fork
            do_redraw("busy_start", 50, 1000, cyc);
            begin
                repeat (50) @(negedge clk);
                start      = 1'b1;
                board[120] = 1'b0;
                board[150] = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        d0 = done_count;
        x0 = frame_xfers;
        repeat (20) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || done_count != d0 || frame_xfers != x0) begin
            n_err++;
            $display("FAIL busy_start_queued: got busy=%b extra_done=%0d extra_xfers=%0d, required 0 0 0",
                     busy, done_count - d0, frame_xfers - x0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int g, cyc, n;
        frame_xfers = 0;
        n = push_frame(board);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        g = 0;
        while (frame_xfers < 3 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        n_vec++;
        if (bif.plot !== 1'b1 || n != 50) begin
            n_err++;
            $display("FAIL rst_in_pixel: got plot=%b model_pixels=%0d, required 1 50", bif.plot, n);
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (bif.plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_ctrl: got plot=%b busy=%b done=%b, required 0 0 0",
                     bif.plot, busy, done);
        end
        n_vec++;
        if (bif.x !== 8'd0 || bif.y !== 7'd0 || bif.colour !== 3'd0) begin
            n_err++;
            $display("FAIL rst_mid_data: got x=%0d y=%0d colour=%0d, required 0 0 0",
                     bif.x, bif.y, bif.colour);
        end
        @(negedge clk);
        resetn = 1'b1;
        sb_q.delete();
        m_prev       = '0;
        m_prev_valid = 1'b0;
        do_redraw("after_reset", 5000, 6000, cyc);
    endtask

    initial begin
        bif.plot_ready = 1'b1;
        test_reset();
        test_full_frame();
        test_incremental();
        test_no_change();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
